// File: rtl/multicaster_v2.sv
// Per-PE multicaster: latches a PE tag, buffers a kernel of weights, forwards matching
// column-bus broadcasts to the PE with a cyclic weight read, and holds PE results for the bus.
module multicaster_v2 #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_COL    = 4,
  parameter int WBUF_DEPTH = 16,
  parameter int KS_W       = 8,
  localparam int TW        = $clog2(NUM_COL) + 1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [TW-1:0]           tag_in,
  input  logic                    flush_tag,
  output logic                    tag_lock,
  input  logic                    flush_kernel,
  input  logic [KS_W-1:0]         kernel_size,
  input  logic                    fltr_valid,
  input  logic [DATA_WIDTH-1:0]   fltr_data,
  output logic                    fltr_ready,
  output logic                    kernel_busy,
  input  logic                    bus_valid,
  input  logic [TW-1:0]           bus_id,
  input  logic [DATA_WIDTH-1:0]   ifmap_in,
  input  logic [2*DATA_WIDTH-1:0] psum_in,
  output logic                    bus_ready,
  output logic                    pe_en,
  output logic [DATA_WIDTH-1:0]   pe_ifmap,
  output logic [DATA_WIDTH-1:0]   pe_fltr,
  output logic [2*DATA_WIDTH-1:0] pe_psum,
  input  logic                    pe_ready,
  input  logic                    pe_valid,
  input  logic [2*DATA_WIDTH-1:0] pe_result,
  output logic                    res_valid,
  output logic [2*DATA_WIDTH-1:0] res_data,
  input  logic                    res_ready
);

  localparam int PW = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;
  localparam int KW = $clog2(WBUF_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_e;

  state_e                  state_q, state_d;
  logic [TW-1:0]           tag_q;
  logic                    tag_lock_q;
  logic [KW-1:0]           klen_q, klen_d;
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0]   wbuf_q [WBUF_DEPTH];
  logic                    pe_en_q;
  logic [DATA_WIDTH-1:0]   pe_ifmap_q, pe_fltr_q;
  logic [2*DATA_WIDTH-1:0] pe_psum_q;
  logic                    res_valid_q;
  logic [2*DATA_WIDTH-1:0] res_data_q;

  logic match, fire, wr_en, load_last, rd_last;

  // A flush in the same cycle as a matching beat aborts the kernel, so that beat is not fired.
  assign match     = (bus_id == tag_q) || (bus_id == {TW{1'b1}});
  assign fire      = (state_q == RUN) && bus_valid && match && pe_ready && !res_valid_q && !flush_kernel;
  assign wr_en     = (state_q == LOAD) && fltr_valid && !flush_kernel;
  assign load_last = (KW'(wr_ptr_q) + KW'(1)) == klen_q;
  assign rd_last   = (KW'(rd_ptr_q) + KW'(1)) == klen_q;

  assign tag_lock    = tag_lock_q;
  assign fltr_ready  = (state_q == LOAD);
  assign kernel_busy = (state_q == LOAD);
  assign bus_ready   = !match || fire;
  assign pe_en       = pe_en_q;
  assign pe_ifmap    = pe_ifmap_q;
  assign pe_fltr     = pe_fltr_q;
  assign pe_psum     = pe_psum_q;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;

  always_comb begin
    state_d  = state_q;
    klen_d   = klen_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_kernel) begin
      klen_d   = (kernel_size > KS_W'(WBUF_DEPTH)) ? KW'(WBUF_DEPTH) : KW'(kernel_size);
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      state_d  = (kernel_size == '0) ? IDLE : LOAD;
    end else begin
      case (state_q)
        LOAD: begin
          if (fltr_valid) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
            if (load_last) begin
              state_d  = RUN;
              rd_ptr_d = '0;
            end
          end
        end
        RUN: begin
          if (fire) rd_ptr_d = rd_last ? '0 : rd_ptr_q + PW'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      klen_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      tag_q       <= '0;
      tag_lock_q  <= 1'b0;
      pe_en_q     <= 1'b0;
      pe_ifmap_q  <= '0;
      pe_fltr_q   <= '0;
      pe_psum_q   <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      state_q  <= state_d;
      klen_q   <= klen_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (flush_tag) begin
        tag_q      <= tag_in;
        tag_lock_q <= 1'b1;
      end
      pe_en_q <= fire;
      if (fire) begin
        pe_ifmap_q <= ifmap_in;
        pe_psum_q  <= psum_in;
        pe_fltr_q  <= wbuf_q[rd_ptr_q];
      end
      // A new result wins over a same-cycle drain, keeping the holding register full.
      if (pe_valid) begin
        res_valid_q <= 1'b1;
        res_data_q  <= pe_result;
      end else if (res_ready) begin
        res_valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) wbuf_q[wr_ptr_q] <= fltr_data;
  end

endmodule
